// File: rtl/pixel_fetch_rr_pkg.sv
// Shared constants and width helpers for the pixel fetch engine and its FIFO.
package pixel_fetch_pkg;

  localparam int unsigned FRAME_WORDS   = 115200;
  localparam int unsigned FETCH_DEPTH   = 8;
  localparam int unsigned NUM_COLOUR_CH = 3;

  // Width of a counter that must hold 0..n inclusive.
  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

  // Width of an index into n items, never less than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pixel_fetch_rr_if.sv
// Memory read port plus round-robin channel output bus of pixel_fetch_rr.
interface pixel_fetch_rr_if
  import pixel_fetch_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned NUM_CH = NUM_COLOUR_CH,
  parameter int unsigned CH_W   = idx_w(NUM_CH)
);

  logic              req_rts;
  logic              req_rtr;
  logic [ADDR_W-1:0] req_addr;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;

  logic [DATA_W-1:0] out_data;
  logic [NUM_CH-1:0] out_rts;
  logic [NUM_CH-1:0] out_rtr;
  logic [CH_W-1:0]   ch_idx;

  // Fetch-engine side
  modport master (
    output req_rts, req_addr, out_data, out_rts, ch_idx,
    input  req_rtr, rsp_valid, rsp_data, out_rtr
  );

  // Frame memory and channel pipelines side
  modport slave (
    input  req_rts, req_addr, out_data, out_rts, ch_idx,
    output req_rtr, rsp_valid, rsp_data, out_rtr
  );

endinterface

// File: rtl/pixel_fetch_rr_fifo.sv
// Synchronous FIFO with occupancy count and synchronous clear; shared by display blocks.
module pf_sync_fifo
  import pixel_fetch_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = FETCH_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_,
  input  logic                   clr,
  input  logic                   push,
  input  logic                   pop,
  input  logic [DATA_W-1:0]      wdata,
  output logic [DATA_W-1:0]      rdata,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = cnt_w(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  rptr;

  assign rdata = mem[rptr];
  assign full  = (level == LVL_W'(DEPTH));
  assign empty = (level == '0);

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else if (clr) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_W'(1);
      if (pop)  rptr <= rptr + PTR_W'(1);
      level <= level + LVL_W'(push) - LVL_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clr) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/pixel_fetch_rr.sv
// Credit-throttled frame fetch with round-robin channel delivery and frame restart.
// Optional sticky response/overflow checking is built when PIXEL_FETCH_ERR_CHK_EN is defined.
module pixel_fetch_rr
  import pixel_fetch_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 17,
  parameter int unsigned NUM_ADDRS = FRAME_WORDS,
  parameter int unsigned DEPTH     = FETCH_DEPTH,
  parameter int unsigned NUM_CH    = NUM_COLOUR_CH
) (
  input  logic                   clk,
  input  logic                   rst_,
  input  logic                   start,
  pixel_fetch_rr_if.master       bus,
  output logic                   frame_done,
  output logic [$clog2(DEPTH):0] level,
  output logic                   err
);

  localparam int unsigned LVL_W = cnt_w(DEPTH);
  localparam int unsigned CH_W  = idx_w(NUM_CH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_ADDRS - 1);
  localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(NUM_CH - 1);

  logic [LVL_W-1:0]  outstanding;
  logic [LVL_W-1:0]  drop;
  logic [LVL_W:0]    credit;
  logic [ADDR_W-1:0] req_addr_q;
  logic [ADDR_W-1:0] deliv_cnt;
  logic [CH_W-1:0]   ch_q;
  logic              req_xfc;
  logic              out_xfc;
  logic              push;
  logic              rsp_dec;
  logic              bad_rsp;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_rdata;

  // Credit counts in-flight requests (including ones to be dropped) so every response has a slot.
  assign credit       = {1'b0, outstanding} + {1'b0, level};
  assign bus.req_rts  = rst_ & ~start & (credit < (LVL_W+1)'(DEPTH));
  assign req_xfc      = bus.req_rts & bus.req_rtr;
  assign bus.req_addr = req_addr_q;

  assign bus.ch_idx   = ch_q;
  assign bus.out_data = fifo_rdata;
  assign bus.out_rts  = NUM_CH'(!fifo_empty) << ch_q;
  assign out_xfc      = |(bus.out_rts & bus.out_rtr);

`ifdef PIXEL_FETCH_ERR_CHK_EN
  assign bad_rsp = bus.rsp_valid & ((outstanding == '0) | ((drop == '0) & fifo_full));
  assign rsp_dec = bus.rsp_valid & (outstanding != '0);

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_)        err <= 1'b0;
    else if (bad_rsp) err <= 1'b1;
  end
`else
  logic unused_full;

  assign bad_rsp     = 1'b0;
  assign rsp_dec     = bus.rsp_valid;
  assign err         = 1'b0;
  assign unused_full = fifo_full;
`endif

  assign push = bus.rsp_valid & (drop == '0) & ~bad_rsp;

  pf_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_  (rst_),
    .clr   (start),
    .push  (push),
    .pop   (out_xfc),
    .wdata (bus.rsp_data),
    .rdata (fifo_rdata),
    .level (level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      req_addr_q  <= '0;
      outstanding <= '0;
      drop        <= '0;
      deliv_cnt   <= '0;
      ch_q        <= '0;
      frame_done  <= 1'b0;
    end else if (start) begin
      // Everything still in flight becomes a drop; a response landing now is already consumed.
      req_addr_q  <= '0;
      deliv_cnt   <= '0;
      ch_q        <= '0;
      outstanding <= outstanding - LVL_W'(rsp_dec);
      drop        <= outstanding - LVL_W'(rsp_dec);
      frame_done  <= out_xfc & (deliv_cnt == LAST_ADDR);
    end else begin
      if (req_xfc)
        req_addr_q <= (req_addr_q == LAST_ADDR) ? '0 : req_addr_q + ADDR_W'(1);
      outstanding <= outstanding + LVL_W'(req_xfc) - LVL_W'(rsp_dec);
      if (bus.rsp_valid && drop != '0)
        drop <= drop - LVL_W'(1);
      if (out_xfc) begin
        ch_q      <= (ch_q == LAST_CH) ? '0 : ch_q + CH_W'(1);
        deliv_cnt <= (deliv_cnt == LAST_ADDR) ? '0 : deliv_cnt + ADDR_W'(1);
      end
      frame_done <= out_xfc & (deliv_cnt == LAST_ADDR);
    end
  end

endmodule

// File: tb/tb_pixel_fetch_rr.sv
// Scoreboard bench for pixel_fetch_rr: 16-word frame, 8-deep FIFO, 3 channels.
`timescale 1ns/1ps
module tb_pixel_fetch_rr;

  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 17;
  localparam int unsigned NA  = 16;
  localparam int unsigned DP  = 8;
  localparam int unsigned NCH = 3;
  localparam int unsigned CW  = 2;

  logic       clk = 1'b0;
  logic       rst_ = 1'b0;
  logic       start = 1'b0;
  logic       frame_done;
  logic       err;
  logic [3:0] level;

  pixel_fetch_rr_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_CH(NCH), .CH_W(CW)) bus ();

  pixel_fetch_rr #(
    .DATA_W    (DW),
    .ADDR_W    (AW),
    .NUM_ADDRS (NA),
    .DEPTH     (DP),
    .NUM_CH    (NCH)
  ) dut (
    .clk        (clk),
    .rst_       (rst_),
    .start      (start),
    .bus        (bus),
    .frame_done (frame_done),
    .level      (level),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int unsigned ch;
    bit          last;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          budget  = 0;
  int          lat     = 1;
  int          cyc     = 0;
  bit          inj     = 1'b0;
  int          fd_count = 0;
  bit          fd_pend  = 1'b0;
  int unsigned exp_addr = 0;
  int unsigned exp_ch   = 0;
  logic [AW-1:0] pend_addr[$];
  int            pend_due[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_words(input int n);
    for (int i = 0; i < n; i++) begin
      sb.push_back('{data: 32'hA500_0000 | exp_addr, ch: exp_ch, last: (exp_addr == NA - 1)});
      exp_addr = (exp_addr + 1) % NA;
      exp_ch   = (exp_ch + 1) % NCH;
    end
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 500 && sb.size() != 0; i++) @(posedge clk);
    step(2);
    chk(nm, sb.size(), 0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_req_addr"}, bus.req_addr, 0);
    chk({tag, "_req_rts"}, bus.req_rts, 0);
    chk({tag, "_out_rts"}, bus.out_rts, 0);
    chk({tag, "_ch_idx"}, bus.ch_idx, 0);
    chk({tag, "_level"}, level, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  // Frame memory: fixed latency, data is a tag plus the requested address.
  initial begin
    bus.req_rtr   = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_data  = '0;
    forever begin
      @(posedge clk);
      if (!rst_) begin
        pend_addr.delete();
        pend_due.delete();
      end else if (bus.req_rts && bus.req_rtr) begin
        pend_addr.push_back(bus.req_addr);
        pend_due.push_back(cyc + lat);
        budget--;
      end
      cyc++;
      #1;
      bus.rsp_valid = 1'b0;
      if (pend_due.size() != 0 && pend_due[0] <= cyc) begin
        bus.rsp_valid = 1'b1;
        bus.rsp_data  = 32'hA500_0000 | 32'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end else if (inj) begin
        bus.rsp_valid = 1'b1;
        bus.rsp_data  = 32'hDEAD_BEEF;
        inj = 1'b0;
      end
      bus.req_rtr = (budget > 0);
    end
  end

  // Monitor: every delivered word is checked against the scoreboard head.
  always @(negedge clk) begin
    if (rst_) begin
      if (fd_pend || frame_done) begin
        chk("frame_done", frame_done, fd_pend);
        if (frame_done) fd_count++;
      end
      fd_pend = 1'b0;
      if (|(bus.out_rts & bus.out_rtr)) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_word: got 0x%0h, expected no delivery", bus.out_data);
        end else begin
          e = sb.pop_front();
          chk("out_data", bus.out_data, e.data);
          chk("out_rts", bus.out_rts, 32'd1 << e.ch);
          chk("ch_idx", bus.ch_idx, e.ch);
          fd_pend = e.last;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.out_rtr = '0;
    step(3);
    chk_reset_state("rst");
    rst_ = 1'b1;
    step(2);

    // Basic round-robin delivery, 1-cycle memory
    bus.out_rtr = 3'b111;
    lat = 1;
    expect_words(4);
    budget += 4;
    drain("t1_drain");
    chk("t1_req_addr", bus.req_addr, 4);
    chk("t1_level", level, 0);

    // Credit throttle with all channels stalled
    bus.out_rtr = 3'b000;
    expect_words(20);
    budget += 20;
    step(30);
    chk("t2_level_full", level, 8);
    chk("t2_req_rts_low", bus.req_rts, 0);
    chk("t2_ch_hold", bus.ch_idx, 1);
    bus.out_rtr = 3'b111;
    drain("t2_drain");

    // Free-running across two frame wraps
    expect_words(32);
    budget += 32;
    drain("t3_drain");
    chk("t3_frame_pulses", fd_count, 3);
    chk("t3_req_addr_wrap", bus.req_addr, 8);

    // Channel 1 stall holds the arbiter
    bus.out_rtr = 3'b101;
    expect_words(6);
    budget += 6;
    step(25);
    chk("t5_ch_idx", bus.ch_idx, 1);
    chk("t5_out_rts", bus.out_rts, 3'b010);
    chk("t5_level", level, 4);
    chk("t5_pending", sb.size(), 4);
    bus.out_rtr = 3'b111;
    drain("t5_drain");

    // Restart with three requests in flight
    lat = 6;
    budget += 3;
    for (int i = 0; i < 50 && budget != 0; i++) step(1);
    chk("t4_issued", budget, 0);
    start = 1'b1;
    @(negedge clk);
    chk("t4_req_rts_in_start", bus.req_rts, 0);
    step(1);
    start = 1'b0;
    chk("t4_level_after", level, 0);
    chk("t4_req_addr_after", bus.req_addr, 0);
    chk("t4_ch_after", bus.ch_idx, 0);
    exp_addr = 0;
    exp_ch   = 0;
    expect_words(5);
    budget += 5;
    drain("t4_drain");
    lat = 1;

`ifdef PIXEL_FETCH_ERR_CHK_EN
    inj = 1'b1;
    step(3);
    chk("t6_err_set", err, 1);
    chk("t6_level_kept", level, 0);
    step(5);
    chk("t6_err_sticky", err, 1);
`else
    chk("t6_err_tied", err, 0);
`endif

    rst_ = 1'b0;
    #1;
    chk_reset_state("rst2");
    step(1);
    rst_ = 1'b1;
    step(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
